// File: rtl/fixed_point_mac_acc_if.sv
// Purpose: job control, operand stream and result bundle for the Q4.12 MAC engine.
// Latency: none, wires only.
// Backpressure: operands on in_valid/in_ready, results on out_valid/out_ready.
// Optional: FXP_MAC_BIAS_EN adds the bias field sampled with start.
interface fixed_point_mac_acc_if #(
    parameter int TOTAL_WIDTH = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 8
);
    logic                          start;
    logic [LEN_WIDTH-1:0]          len;
    logic                          busy;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [TOTAL_WIDTH-1:0] in_a;
    logic signed [TOTAL_WIDTH-1:0] in_b;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [ACC_WIDTH-1:0]   out_acc;
    logic signed [TOTAL_WIDTH-1:0] out_q;
    logic                          out_ovf;
`ifdef FXP_MAC_BIAS_EN
    logic signed [TOTAL_WIDTH-1:0] bias;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready, bias,
        input  busy, in_ready, out_valid, out_acc, out_q, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready, bias,
        output busy, in_ready, out_valid, out_acc, out_q, out_ovf
    );
`else
    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, out_valid, out_acc, out_q, out_ovf
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, out_valid, out_acc, out_q, out_ovf
    );
`endif
endinterface

// File: rtl/fixed_point_mac_acc.sv
// Purpose: streaming Q4.12 dot-product engine, saturating Q8.24 accumulator plus Q4.12 image.
// Latency: out_valid rises 2 cycles after the last operand handshake (2 cycles after start if len==0).
// Backpressure: in_ready only while accumulating; result held stable until out_ready.
// Optional: FXP_MAC_BIAS_EN preloads the accumulator with bias<<<FRAC_WIDTH sampled with start.
module fixed_point_mac_acc #(
    parameter int INT_WIDTH   = 4,
    parameter int FRAC_WIDTH  = 12,
    parameter int TOTAL_WIDTH = INT_WIDTH + FRAC_WIDTH,
    parameter int ACC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fixed_point_mac_acc_if.slave bus
);
    localparam int PROD_WIDTH = 2 * TOTAL_WIDTH;
    localparam int SUM_WIDTH  = ACC_WIDTH + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    // Accumulator values bounding the representable Q4.12 range, in accumulator scale.
    localparam logic signed [ACC_WIDTH-1:0] Q_HI =
        ACC_WIDTH'(((64'sd1 <<< (TOTAL_WIDTH-1)) - 64'sd1) <<< FRAC_WIDTH);
    localparam logic signed [ACC_WIDTH-1:0] Q_LO =
        ACC_WIDTH'((-(64'sd1 <<< (TOTAL_WIDTH-1))) <<< FRAC_WIDTH);
    localparam logic signed [TOTAL_WIDTH-1:0] Q_MAX = {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
    localparam logic signed [TOTAL_WIDTH-1:0] Q_MIN = {1'b1, {(TOTAL_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [LEN_WIDTH-1:0]          remaining;
    logic                          job_start;
    logic                          in_hs;
    logic                          last_hs;
    logic                          out_hs;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic                          prod_vld;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_init;
    logic signed [ACC_WIDTH-1:0]   acc_sat;
    logic signed [SUM_WIDTH-1:0]   sum;
    logic                          sat_hit;
    logic                          ovf;
    logic signed [TOTAL_WIDTH-1:0] q;

    assign job_start = (state_q == IDLE) && bus.start;
    assign in_hs     = (state_q == ACCUM) && bus.in_valid;
    assign last_hs   = in_hs && (remaining == LEN_WIDTH'(1));
    assign out_hs    = (state_q == DONE) && bus.out_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: job sequencing from start through the result handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.len != '0) ? ACCUM : DRAIN;
                end
            end
            ACCUM: begin
                if (last_hs) begin
                    state_d = DRAIN;
                end
            end
            // No new operands enter here, so the one product still in stage 1
            // is folded into the accumulator on this same edge.
            DRAIN:   state_d = DONE;
            DONE: begin
                if (out_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count of operand pairs still owed by the producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (job_start) begin
            remaining <= bus.len;
        end else if (in_hs) begin
            remaining <= remaining - LEN_WIDTH'(1);
        end
    end

    // Stage 1: full-precision signed product of the accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= in_hs;
            if (in_hs) begin
                prod <= PROD_WIDTH'(bus.in_a) * PROD_WIDTH'(bus.in_b);
            end
        end
    end

`ifdef FXP_MAC_BIAS_EN
    assign acc_init = ACC_WIDTH'(bus.bias) <<< FRAC_WIDTH;
`else
    assign acc_init = '0;
`endif

    // Stage 2 datapath: one guard bit exposes overflow, which clamps instead of wrapping.
    always_comb begin
        sum     = SUM_WIDTH'(acc) + SUM_WIDTH'(prod);
        sat_hit = sum[SUM_WIDTH-1] != sum[SUM_WIDTH-2];
        acc_sat = sum[ACC_WIDTH-1:0];
        if (sat_hit) begin
            acc_sat = sum[SUM_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator and sticky overflow: loaded on start, updated per product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (job_start) begin
            acc <= acc_init;
            ovf <= 1'b0;
        end else if (prod_vld) begin
            acc <= acc_sat;
            if (sat_hit) begin
                ovf <= 1'b1;
            end
        end
    end

    // Q4.12 image: clamp outside the Q4.12 range, otherwise floor-truncate.
    always_comb begin
        q = TOTAL_WIDTH'(acc >>> FRAC_WIDTH);
        if (acc > Q_HI) begin
            q = Q_MAX;
        end else if (acc < Q_LO) begin
            q = Q_MIN;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_acc   = acc;
    assign bus.out_q     = q;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_fixed_point_mac_acc.sv
// Bench for fixed_point_mac_acc: directed vector table, reset/abort sequence,
// then randomized jobs scored against an arithmetic reference model.
// Build with FXP_MAC_BIAS_EN defined to also cover the bias preload.
module tb_fixed_point_mac_acc;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fixed_point_mac_acc_if bus ();

    fixed_point_mac_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string       name;
        int          n;
        logic [15:0] a[3];
        logic [15:0] b[3];
        logic [15:0] bias;
        logic [31:0] acc;
        logic [15:0] q;
        logic        ovf;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] va[$];
    logic [15:0] vb[$];
    logic [15:0] cur_bias = 16'h0000;
    int          nvec = 0;
    int          nerr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input int n,
                           input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1,
                           input logic [15:0] a2, input logic [15:0] b2,
                           input logic [15:0] bias,
                           input logic [31:0] acc, input logic [15:0] q, input logic ovf);
        vec_t v;
        v.name = name; v.n = n;
        v.a[0] = a0; v.b[0] = b0;
        v.a[1] = a1; v.b[1] = b1;
        v.a[2] = a2; v.b[2] = b2;
        v.bias = bias; v.acc = acc; v.q = q; v.ovf = ovf;
        tbl.push_back(v);
    endtask

    // Reference: exact integer sum in Q8.24, clamped to the 32-bit range after
    // every term; Q4.12 result is floor(acc / 4096) clamped to 16-bit range.
    task automatic model(input int n, output logic [31:0] m_acc, output logic [15:0] m_q,
                         output logic m_ovf);
        longint acc;
        longint fl;
        acc   = longint'($signed(cur_bias)) * 4096;
        m_ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc += longint'($signed(va[i])) * longint'($signed(vb[i]));
            if (acc > 64'sd2147483647) begin
                acc   = 64'sd2147483647;
                m_ovf = 1'b1;
            end else if (acc < -64'sd2147483648) begin
                acc   = -64'sd2147483648;
                m_ovf = 1'b1;
            end
        end
        m_acc = 32'(acc);
        fl = (acc - (((acc % 4096) + 4096) % 4096)) / 4096;
        if (fl > 32767) fl = 32767;
        else if (fl < -32768) fl = -32768;
        m_q = 16'(fl);
    endtask

    // One complete job: start, feed va/vb, check latency, optional result stall
    // (with ignored start pulses), result handshake; returns captured outputs.
    task automatic run_job(input string tag, input int n, input bit gaps, input int rdy_wait,
                           input bit poke, output logic [31:0] g_acc, output logic [15:0] g_q,
                           output logic g_ovf);
        int idx;
        int guard;
        bit hs;
        bus.start = 1'b1;
        bus.len   = 8'(n);
`ifdef FXP_MAC_BIAS_EN
        bus.bias  = cur_bias;
`endif
        tick();
        bus.start = 1'b0;
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        idx   = 0;
        guard = 0;
        while (idx < n && guard < 400) begin
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_a     = va[idx];
            bus.in_b     = vb[idx];
            hs           = bus.in_valid && bus.in_ready;
            tick();
            if (hs) idx++;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk({tag, " pairs_taken"}, 32'(idx), 32'(n));
        // Now one cycle after the last handshake (or after start): not yet valid.
        chk({tag, " valid_early"}, 32'(bus.out_valid), 32'd0);
        tick();
        chk({tag, " valid_lat2"}, 32'(bus.out_valid), 32'd1);
        g_acc = bus.out_acc;
        g_q   = $unsigned(bus.out_q);
        g_ovf = bus.out_ovf;
        for (int i = 0; i < rdy_wait; i++) begin
            bus.start = poke && (i == 1);
            bus.len   = 8'd2;
            tick();
            bus.start = 1'b0;
            chk({tag, " hold_flags_q"}, {bus.out_valid, bus.busy, bus.out_ovf, 13'b0, bus.out_q},
                {1'b1, 1'b1, g_ovf, 13'b0, g_q});
            chk({tag, " hold_acc"}, bus.out_acc, g_acc);
        end
        bus.out_ready = 1'b1;
        bus.start     = poke;
        bus.len       = 8'd2;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk({tag, " idle_after"}, 32'({bus.out_valid, bus.busy}), 32'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'($signed(10'($urandom)));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] g_acc;
        logic [15:0] g_q;
        logic        g_ovf;
        logic [31:0] m_acc;
        logic [15:0] m_q;
        logic        m_ovf;
        bit          saw_vld;
        int          n;

        add_vec("mix3",     3, 16'h1000, 16'h1000, 16'h2000, 16'h0800, 16'hF000, 16'h0400,
                16'h0000, 32'h01C0_0000, 16'h1C00, 1'b0);
        add_vec("qsat_hi",  2, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h0000, 16'h0000,
                16'h0000, 32'h6200_0000, 16'h7FFF, 1'b0);
        add_vec("acc_max",  3, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                16'h0000, 32'h7FFF_FFFF, 16'h7FFF, 1'b1);
        add_vec("floor_m1", 1, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
        add_vec("len0",     0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 32'h0000_0000, 16'h0000, 1'b0);
        add_vec("acc_min",  3, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF,
                16'h0000, 32'h8000_0000, 16'h8000, 1'b1);
        add_vec("q_lo_edge", 1, 16'h8000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 32'hF800_0000, 16'h8000, 1'b0);
        add_vec("q_hi_edge", 1, 16'h7FFF, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 32'h07FF_F000, 16'h7FFF, 1'b0);
`ifdef FXP_MAC_BIAS_EN
        add_vec("bias_mix3", 3, 16'h1000, 16'h1000, 16'h2000, 16'h0800, 16'hF000, 16'h0400,
                16'h0800, 32'h0240_0000, 16'h2400, 1'b0);
        add_vec("bias_len0", 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'hF800, 32'hFF80_0000, 16'hF800, 1'b0);
`endif

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.out_ready = 1'b0;
`ifdef FXP_MAC_BIAS_EN
        bus.bias      = 16'h0000;
`endif
        repeat (3) tick();
        rst = 1'b0;
        chk("reset flags", 32'({bus.busy, bus.in_ready, bus.out_valid, bus.out_ovf}), 32'd0);
        chk("reset acc", bus.out_acc, 32'd0);
        chk("reset q", 32'($unsigned(bus.out_q)), 32'd0);

        // Directed table; first entry also stalls out_ready 5 cycles with start pokes.
        for (int i = 0; i < tbl.size(); i++) begin
            va.delete();
            vb.delete();
            for (int k = 0; k < tbl[i].n; k++) begin
                va.push_back(tbl[i].a[k]);
                vb.push_back(tbl[i].b[k]);
            end
            cur_bias = tbl[i].bias;
            run_job(tbl[i].name, tbl[i].n, (i % 2) == 1, (i == 0) ? 5 : (i % 3), i == 0,
                    g_acc, g_q, g_ovf);
            chk({tbl[i].name, " out_acc"}, g_acc, tbl[i].acc);
            chk({tbl[i].name, " out_q"}, 32'(g_q), 32'(tbl[i].q));
            chk({tbl[i].name, " out_ovf"}, 32'(g_ovf), 32'(tbl[i].ovf));
        end

        // Reset in the middle of accumulation: job aborted, no result ever appears.
        cur_bias     = 16'h0000;
        bus.start    = 1'b1;
        bus.len      = 8'd4;
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h4000;
        bus.in_b     = 16'h4000;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort flags", 32'({bus.busy, bus.in_ready, bus.out_valid, bus.out_ovf}), 32'd0);
        chk("abort acc", bus.out_acc, 32'd0);
        saw_vld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_vld |= bus.out_valid;
        end
        chk("abort no_valid", 32'(saw_vld), 32'd0);

        // Randomized jobs against the reference model.
        for (int j = 0; j < 40; j++) begin
            n = $urandom_range(0, 12);
            va.delete();
            vb.delete();
            for (int k = 0; k < n; k++) begin
                va.push_back(pick_operand());
                vb.push_back(pick_operand());
            end
`ifdef FXP_MAC_BIAS_EN
            cur_bias = 16'($urandom);
`else
            cur_bias = 16'h0000;
`endif
            model(n, m_acc, m_q, m_ovf);
            run_job("rand", n, 1'b1, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                    g_acc, g_q, g_ovf);
            chk("rand out_acc", g_acc, m_acc);
            chk("rand out_q", 32'(g_q), 32'(m_q));
            chk("rand out_ovf", 32'(g_ovf), 32'(m_ovf));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
